// File: rtl/reg_file.sv
// 32 x DATA_W register file: two combinational read ports, one clocked write port, R[ZERO_REG] reads 0.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to a matching read port.
`timescale 1ns/10ps

module reg_file #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        ReadRegister1,
   input  logic [4:0]        ReadRegister2,
   input  logic [4:0]        WriteRegister,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              RegWrite,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   localparam logic [4:0] ZERO_ADDR = 5'(ZERO_REG);

   logic [31:0]       we;
   logic [DATA_W-1:0] q [32];

   // 5:32 write decoder, one-hot and gated by RegWrite; the zero register is never enabled
   always_comb begin
      we = '0;
      if (RegWrite && (WriteRegister != ZERO_ADDR))
         we[WriteRegister] = 1'b1;
   end

   for (genvar i = 0; i < 32; i++) begin : g_entry
      if (i == ZERO_REG) begin : g_zero
         assign q[i] = '0;
      end else begin : g_reg
         logic [DATA_W-1:0] r;

         always_ff @(posedge clk) begin
            if (!reset)
               r <= '0;
            else if (we[i])
               r <= WriteData;
         end

         assign q[i] = r;
      end
   end

`ifdef REG_FILE_BYPASS_EN
   logic byp1, byp2;

   assign byp1 = RegWrite && reset && (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_ADDR);
   assign byp2 = RegWrite && reset && (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_ADDR);
`endif

   always_comb begin
      ReadData1 = q[ReadRegister1];
      ReadData2 = q[ReadRegister2];
`ifdef REG_FILE_BYPASS_EN
      if (byp1) ReadData1 = WriteData;
      if (byp2) ReadData2 = WriteData;
`endif
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed table-driven bench for reg_file; expectations follow REG_FILE_BYPASS_EN when defined.
`timescale 1ns/10ps

module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [63:0] BASE = 64'h0123_4567_89AB_CD00;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk;
   logic        reset;
   logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
   logic [63:0] WriteData;
   logic        RegWrite;
   logic [63:0] ReadData1, ReadData2;

   int unsigned vectors;
   int unsigned miscompares;

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [63:0] e1;
      logic [63:0] e2;
   } vec_t;

   vec_t tbl [14];

   reg_file #(.DATA_W(64), .ZERO_REG(31)) dut (
      .clk          (clk),
      .reset        (reset),
      .ReadRegister1(ReadRegister1),
      .ReadRegister2(ReadRegister2),
      .WriteRegister(WriteRegister),
      .WriteData    (WriteData),
      .RegWrite     (RegWrite),
      .ReadData1    (ReadData1),
      .ReadData2    (ReadData2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                               input logic [4:0] ra1, input logic [4:0] ra2,
                               input logic [63:0] e1, input logic [63:0] e2);
      vec_t v;
      v.rst = rst; v.we = we; v.wa = wa; v.wd = wd;
      v.ra1 = ra1; v.ra2 = ra2; v.e1 = e1; v.e2 = e2;
      return v;
   endfunction

   initial begin
      vectors     = 0;
      miscompares = 0;

      // Expected values are the pre-edge reads for each row; R[i] = BASE|i from the fill phase
      tbl[0]  = mk(1, 1, 31, ONES,    31,  0, 64'h0,               BASE | 64'd0);
      tbl[1]  = mk(1, 0, 31, ONES,    31, 30, 64'h0,               BASE | 64'd30);
      tbl[2]  = mk(1, 1,  5, 64'hAAAA, 6,  4, BASE | 64'd6,        BASE | 64'd4);
      tbl[3]  = mk(1, 0,  5, 64'h5555, 5,  5, 64'hAAAA,            64'hAAAA);
      tbl[4]  = mk(1, 0,  5, 64'h5555, 5,  5, 64'hAAAA,            64'hAAAA);
      tbl[5]  = mk(1, 0,  5, 64'h5555, 5,  5, 64'hAAAA,            64'hAAAA);
      tbl[6]  = mk(1, 1,  7, 64'h1,    8,  5, BASE | 64'd8,        64'hAAAA);
      tbl[7]  = mk(0, 1,  7, 64'h99,   7,  5, 64'h1,               64'hAAAA);
      tbl[8]  = mk(1, 0,  7, 64'h0,    7,  5, 64'h0,               64'h0);
      tbl[9]  = mk(1, 1,  3, 64'h10,   4, 30, 64'h0,               64'h0);
      tbl[10] = mk(1, 1,  3, 64'h20,   3,  3, BYP ? 64'h20 : 64'h10, BYP ? 64'h20 : 64'h10);
      tbl[11] = mk(1, 0,  3, 64'h0,    3, 31, 64'h20,              64'h0);
      tbl[12] = mk(1, 1,  0, 64'h1234, 0,  1, BYP ? 64'h1234 : 64'h0, 64'h0);
      tbl[13] = mk(1, 0,  0, 64'h0,    1,  0, 64'h0,               64'h1234);

      reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
      ReadRegister1 = '0; ReadRegister2 = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(31 - i);
         #1;
         check("reset_rd1", i, ReadData1, 64'h0);
         check("reset_rd2", i, ReadData2, 64'h0);
      end

      for (int i = 0; i < 31; i++) begin
         @(negedge clk);
         RegWrite      = 1'b1;
         WriteRegister = 5'(i);
         WriteData     = BASE | 64'(i);
      end
      @(negedge clk);
      RegWrite = 1'b0;

      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'((i + 1) % 32);
         #1;
         check("fill_rd1", i, ReadData1, (i == 31) ? 64'h0 : (BASE | 64'(i)));
         check("fill_rd2", i, ReadData2, (((i + 1) % 32) == 31) ? 64'h0 : (BASE | 64'((i + 1) % 32)));
      end

      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         reset         = tbl[k].rst;
         RegWrite      = tbl[k].we;
         WriteRegister = tbl[k].wa;
         WriteData     = tbl[k].wd;
         ReadRegister1 = tbl[k].ra1;
         ReadRegister2 = tbl[k].ra2;
         #1;
         check("tbl_rd1", k, ReadData1, tbl[k].e1);
         check("tbl_rd2", k, ReadData2, tbl[k].e2);
      end

      // Mid-program reset must wipe everything written since, including R0 and R3
      @(negedge clk);
      reset = 1'b0; RegWrite = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(i);
         #1;
         check("rst2_rd1", i, ReadData1, 64'h0);
         check("rst2_rd2", i, ReadData2, 64'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
